// File: rtl/dff_shift_bank.sv
// Parametrised bank of DEPTH x WIDTH registered stages with per-stage valid bits,
// bidirectional shifting, parallel load and registered occupancy tracking.
module dff_shift_bank #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       async_reset,
  input  logic                       sync_clear,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           d_in,
  input  logic                       d_in_valid,
  input  logic [WIDTH*DEPTH-1:0]     load_data,
  output logic [WIDTH*DEPTH-1:0]     parallel_q,
  output logic [DEPTH-1:0]           valid_q,
  output logic [WIDTH-1:0]           shift_out,
  output logic                       shift_out_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned DW = WIDTH * DEPTH;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_UP    = 2'b01;
  localparam logic [1:0] MODE_DOWN  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [DW-1:0]    data_d;
  logic [DEPTH-1:0] valid_d;
  logic [CW-1:0]    count_d;
  logic             full_d;
  logic             empty_d;

  // Next-state data and valid bits; clear outranks the enable, which outranks mode.
  always_comb begin
    data_d  = parallel_q;
    valid_d = valid_q;
    if (sync_clear) begin
      data_d  = {DEPTH{RESET_VAL}};
      valid_d = '0;
    end else if (en) begin
      case (mode)
        MODE_UP: begin
          for (int unsigned i = 1; i < DEPTH; i++) begin
            data_d[i*WIDTH +: WIDTH] = parallel_q[(i-1)*WIDTH +: WIDTH];
            valid_d[i]               = valid_q[i-1];
          end
          data_d[0 +: WIDTH] = d_in;
          valid_d[0]         = d_in_valid;
        end
        MODE_DOWN: begin
          for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
            data_d[i*WIDTH +: WIDTH] = parallel_q[(i+1)*WIDTH +: WIDTH];
            valid_d[i]               = valid_q[i+1];
          end
          data_d[(DEPTH-1)*WIDTH +: WIDTH] = d_in;
          valid_d[DEPTH-1]                 = d_in_valid;
        end
        MODE_LOAD: begin
          data_d  = load_data;
          valid_d = '1;
        end
        MODE_HOLD: ;
        default: ;
      endcase
    end
  end

  // Occupancy derived from the next valid vector so flags land on the same edge.
  always_comb begin
    count_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      count_d = count_d + CW'(valid_d[i]);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      parallel_q <= {DEPTH{RESET_VAL}};
      valid_q    <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
    end else begin
      parallel_q <= data_d;
      valid_q    <= valid_d;
      count      <= count_d;
      full       <= full_d;
      empty      <= empty_d;
    end
  end

  // Element the next shift in the current direction would discard.
  always_comb begin
    if (mode == MODE_DOWN) begin
      shift_out       = parallel_q[0 +: WIDTH];
      shift_out_valid = valid_q[0];
    end else begin
      shift_out       = parallel_q[(DEPTH-1)*WIDTH +: WIDTH];
      shift_out_valid = valid_q[DEPTH-1];
    end
  end

endmodule

// File: tb/tb_dff_shift_bank.sv
// Directed bench for dff_shift_bank: a DEPTH=4 bank and a DEPTH=1 bank.
module tb_dff_shift_bank;

  logic        clk = 1'b0;
  logic        async_reset;
  logic        sync_clear, en, d_in_valid;
  logic [1:0]  mode;
  logic [7:0]  d_in;
  logic [31:0] load_data, parallel_q;
  logic [3:0]  valid_q;
  logic [7:0]  shift_out;
  logic        shift_out_valid, full, empty;
  logic [2:0]  count;

  logic        sync_clear1, en1, d_in_valid1;
  logic [1:0]  mode1;
  logic [7:0]  d_in1, load_data1, parallel_q1, shift_out1;
  logic [0:0]  valid_q1, count1;
  logic        shift_out_valid1, full1, empty1;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  dff_shift_bank #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
    .clk(clk), .async_reset(async_reset), .sync_clear(sync_clear), .en(en),
    .mode(mode), .d_in(d_in), .d_in_valid(d_in_valid), .load_data(load_data),
    .parallel_q(parallel_q), .valid_q(valid_q), .shift_out(shift_out),
    .shift_out_valid(shift_out_valid), .count(count), .full(full), .empty(empty)
  );

  dff_shift_bank #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) dut1 (
    .clk(clk), .async_reset(async_reset), .sync_clear(sync_clear1), .en(en1),
    .mode(mode1), .d_in(d_in1), .d_in_valid(d_in_valid1), .load_data(load_data1),
    .parallel_q(parallel_q1), .valid_q(valid_q1), .shift_out(shift_out1),
    .shift_out_valid(shift_out_valid1), .count(count1), .full(full1), .empty(empty1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  m;
    logic [7:0]  d;
    logic        v;
    logic [31:0] pq;
    logic [3:0]  vq;
    logic [2:0]  cnt;
  } step_t;

  // Hand-computed alternating-direction sequence from an empty, zeroed bank.
  step_t rev [9] = '{
    '{2'b01, 8'hA1, 1'b1, 32'h000000A1, 4'b0001, 3'd1},
    '{2'b01, 8'hB2, 1'b1, 32'h0000A1B2, 4'b0011, 3'd2},
    '{2'b10, 8'hC3, 1'b0, 32'hC30000A1, 4'b0001, 3'd1},
    '{2'b01, 8'hD4, 1'b1, 32'h0000A1D4, 4'b0011, 3'd2},
    '{2'b10, 8'hE5, 1'b1, 32'hE50000A1, 4'b1001, 3'd2},
    '{2'b01, 8'hF6, 1'b1, 32'h0000A1F6, 4'b0011, 3'd2},
    '{2'b01, 8'h07, 1'b1, 32'h00A1F607, 4'b0111, 3'd3},
    '{2'b01, 8'h18, 1'b1, 32'hA1F60718, 4'b1111, 3'd4},
    '{2'b10, 8'h29, 1'b0, 32'h29A1F607, 4'b0111, 3'd3}
  };

  logic [7:0] fill_vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    async_reset = 1'b1;
    sync_clear = 1'b0; en = 1'b0; mode = 2'b00; d_in = '0; d_in_valid = 1'b0; load_data = '0;
    sync_clear1 = 1'b0; en1 = 1'b0; mode1 = 2'b00; d_in1 = '0; d_in_valid1 = 1'b0; load_data1 = '0;
    tick();
    check("reset_pq", 64'(parallel_q), 64'h0);
    check("reset_count", 64'(count), 64'd0);
    check("reset_empty", 64'(empty), 64'd1);
    check("reset_full", 64'(full), 64'd0);
    async_reset = 1'b0;

    // Fill with SHIFT_UP
    en = 1'b1; mode = 2'b01; d_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d_in = fill_vals[i];
      tick();
      check("fill_count", 64'(count), 64'(i + 1));
    end
    check("fill_pq", 64'(parallel_q), 64'h11223344);
    check("fill_full", 64'(full), 64'd1);
    check("fill_shift_out", 64'(shift_out), 64'h11);
    check("fill_shift_out_valid", 64'(shift_out_valid), 64'd1);

    // Drain with invalid entries
    d_in_valid = 1'b0; d_in = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_count", 64'(count), 64'(3 - i));
      check("drain_full", 64'(full), 64'd0);
    end
    check("drain_empty", 64'(empty), 64'd1);
    check("drain_valid", 64'(valid_q), 64'h0);

    // Parallel load then one SHIFT_DOWN
    mode = 2'b11; load_data = 32'hDDCCBBAA;
    tick();
    check("load_pq", 64'(parallel_q), 64'hDDCCBBAA);
    check("load_count", 64'(count), 64'd4);
    check("load_full", 64'(full), 64'd1);
    mode = 2'b10; d_in = 8'hEE; d_in_valid = 1'b1;
    #1;
    check("down_shift_out_pre", 64'(shift_out), 64'hAA);
    tick();
    check("down_pq", 64'(parallel_q), 64'hEEDDCCBB);
    check("down_count", 64'(count), 64'd4);
    check("down_shift_out_post", 64'(shift_out), 64'hBB);

    // Enable low holds everything
    en = 1'b0; mode = 2'b01; d_in = 8'h77; d_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_pq", 64'(parallel_q), 64'hEEDDCCBB);
      check("hold_count", 64'(count), 64'd4);
    end

    // Synchronous clear beats en=0 and LOAD
    sync_clear = 1'b1; mode = 2'b11; load_data = 32'h12345678;
    #1;
    check("clear_pre_pq", 64'(parallel_q), 64'hEEDDCCBB);
    tick();
    sync_clear = 1'b0;
    check("clear_pq", 64'(parallel_q), 64'h0);
    check("clear_valid", 64'(valid_q), 64'h0);
    check("clear_count", 64'(count), 64'd0);
    check("clear_empty", 64'(empty), 64'd1);

    // Back-to-back direction reversal
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      mode = rev[i].m; d_in = rev[i].d; d_in_valid = rev[i].v;
      tick();
      check("rev_pq", 64'(parallel_q), 64'(rev[i].pq));
      check("rev_valid", 64'(valid_q), 64'(rev[i].vq));
      check("rev_count", 64'(count), 64'(rev[i].cnt));
      check("rev_full", 64'(full), 64'(rev[i].cnt == 3'd4));
      check("rev_empty", 64'(empty), 64'(rev[i].cnt == 3'd0));
    end

    // Asynchronous reset mid-cycle while shifting a full bank
    mode = 2'b11; load_data = 32'h99887766;
    tick();
    check("pre_areset_pq", 64'(parallel_q), 64'h99887766);
    mode = 2'b01; d_in_valid = 1'b1;
    #3;
    async_reset = 1'b1;
    #1;
    check("areset_pq", 64'(parallel_q), 64'h0);
    check("areset_valid", 64'(valid_q), 64'h0);
    check("areset_count", 64'(count), 64'd0);
    check("areset_empty", 64'(empty), 64'd1);
    check("areset_full", 64'(full), 64'd0);
    tick();
    check("areset_hold_count", 64'(count), 64'd0);
    async_reset = 1'b0;
    en = 1'b0;

    // DEPTH=1 build
    en1 = 1'b1; mode1 = 2'b01; d_in1 = 8'h5A; d_in_valid1 = 1'b1;
    tick();
    check("d1_pq", 64'(parallel_q1), 64'h5A);
    check("d1_full", 64'(full1), 64'd1);
    check("d1_count", 64'(count1), 64'd1);
    check("d1_shift_out", 64'(shift_out1), 64'h5A);
    mode1 = 2'b10; d_in1 = 8'h00; d_in_valid1 = 1'b0;
    tick();
    check("d1_empty", 64'(empty1), 64'd1);
    check("d1_count0", 64'(count1), 64'd0);
    check("d1_full0", 64'(full1), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
